// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, state encoding and stage-geometry helpers for the SDF FFT scheduler
package fft_pkg;
    localparam int LOG2N = 5;
    localparam int STAGE_REG = 1;
    localparam int TW = LOG2N - 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic int d_s(input int s);
        return 1 << (LOG2N - 1 - s);
    endfunction

    function automatic int lin_s(input int s);
        int a;
        a = 0;
        for (int j = 0; j < s; j++) a += d_s(j) + STAGE_REG;
        return a;
    endfunction

    function automatic int lout();
        return lin_s(LOG2N);
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    localparam int LOUT = lout();
    localparam int TBITS = $clog2(LOUT + 1);
endpackage

// File: rtl/fft_stage_cnt.sv
// fft_stage_cnt: per-stage frame counter driving butterfly select and twiddle index of stage S
module fft_stage_cnt
    import fft_pkg::*;
#(
    parameter int S = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [TBITS-1:0] i_t,
    output logic             o_bf,
    output logic [TW-1:0]    o_tw
);
    localparam int B = LOG2N - 1 - S;
    localparam int LIN = lin_s(S);
    localparam logic [LOG2N-1:0] MASK = LOG2N'((1 << B) - 1);

    logic [LOG2N-1:0] r_cnt;
    logic r_live, r_prim;
    logic w_live;

    // Counting starts on the advance where t reaches this stage's input offset
    assign w_live = r_live | (i_t == TBITS'(LIN));

    always_ff @(posedge clk) begin
        if (rst | i_clr) begin
            r_cnt  <= '0;
            r_live <= 1'b0;
            r_prim <= 1'b0;
        end else if (i_en & w_live) begin
            r_cnt  <= r_cnt + LOG2N'(1);
            r_live <= 1'b1;
            if (&r_cnt[B:0]) r_prim <= 1'b1;
        end
    end

    assign o_bf = r_live & r_cnt[B];
    assign o_tw = (r_prim & ~o_bf) ? TW'((r_cnt & MASK) << S) : '0;
endmodule

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: frame scheduler for the 32-point radix-2 DIF SDF FFT (advance, flush, output tagging)
module fft_stage_sched
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                en,
    output logic                in_zero,
    output logic [LOG2N-1:0]    stage_bf,
    output logic [LOG2N*TW-1:0] tw_addr,
    output logic                out_valid,
    output logic                out_last,
    output logic [LOG2N-1:0]    out_index,
    output logic                busy
);
    state_t r_state, w_next;
    logic [LOG2N-1:0] r_in_cnt, r_ocnt;
    logic [TBITS-1:0] r_t, r_fcnt;
    logic r_olive;
    logic w_accept, w_flush, w_done, w_olive;

    assign w_flush  = r_state == FLUSH;
    assign in_ready = ~w_flush;
    assign w_accept = in_valid & in_ready;
    assign en       = w_accept | w_flush;
    assign in_zero  = w_flush;
    assign busy     = r_state != IDLE;
    assign w_done   = w_flush & (r_fcnt == TBITS'(LOUT - 1));
    assign w_olive  = r_olive | (r_t == TBITS'(LOUT));

    assign out_valid = en & w_olive;
    assign out_last  = out_valid & (&r_ocnt);
    assign out_index = bitrev(r_ocnt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (!in_valid && r_in_cnt == '0) w_next = FLUSH;
            FLUSH:   if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // r_t saturates at the output latency so offset matches fire only once per burst
    always_ff @(posedge clk) begin
        if (rst | w_done) begin
            r_in_cnt <= '0;
            r_t      <= '0;
            r_fcnt   <= '0;
            r_ocnt   <= '0;
            r_olive  <= 1'b0;
        end else if (en) begin
            r_in_cnt <= r_in_cnt + LOG2N'(w_accept);
            r_t      <= (r_t == TBITS'(LOUT)) ? r_t : r_t + TBITS'(1);
            r_fcnt   <= r_fcnt + TBITS'(w_flush);
            if (w_olive) begin
                r_ocnt  <= r_ocnt + LOG2N'(1);
                r_olive <= 1'b1;
            end
        end
    end

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        fft_stage_cnt #(.S(s)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_done),
            .i_en  (en),
            .i_t   (r_t),
            .o_bf  (stage_bf[s]),
            .o_tw  (tw_addr[s*TW +: TW])
        );
    end
endmodule

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: scenario tasks for the FFT scheduler with an output-tag scoreboard
module tb_fft_stage_sched;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic in_ready, en, in_zero, out_valid, out_last, busy;
    logic [4:0] stage_bf, out_index;
    logic [19:0] tw_addr;

    int n_cmp = 0, n_bad = 0, m_en = 0, exp_k = 0;
    logic exp_acc = 1'b0;

    typedef struct {
        logic [4:0] idx;
        logic       last;
        int         due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    localparam int LIN [5] = '{0, 17, 26, 31, 34};

    always #5 clk = ~clk;

    fft_stage_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .en(en),
        .in_zero(in_zero), .stage_bf(stage_bf), .tw_addr(tw_addr), .out_valid(out_valid),
        .out_last(out_last), .out_index(out_index), .busy(busy)
    );

    function automatic logic [4:0] m_rev(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [4:0] m_bf(input int t);
        logic [4:0] r;
        r = '0;
        for (int s = 0; s < 5; s++)
            if (t >= LIN[s]) r[s] = ((((t - LIN[s]) % 32) >> (4 - s)) % 2) == 1;
        return r;
    endfunction

    function automatic logic [19:0] m_tw(input int t);
        logic [19:0] r;
        int c;
        r = '0;
        for (int s = 0; s < 5; s++) begin
            c = (t - LIN[s]) % 32;
            if (t - LIN[s] >= (32 >> s) && ((c >> (4 - s)) % 2) == 0)
                r[s*4 +: 4] = 4'((c % (16 >> s)) << s);
        end
        return r;
    endfunction

    // Each accepted sample k of a burst must surface as bin bitrev(k) exactly 36 advances later
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_en = 0;
        end else begin
            if (exp_acc) sb.push_back('{m_rev(5'(exp_k % 32)), (exp_k % 32) == 31, m_en + 36});
            if (out_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow got out_index=%0d with no expected result", out_index);
                end else begin
                    e = sb.pop_front();
                    if (out_index !== e.idx || out_last !== e.last || m_en !== e.due) begin
                        n_bad++;
                        $display("FAIL sb_output got idx=%0d last=%b adv=%0d want idx=%0d last=%b adv=%0d",
                                 out_index, out_last, m_en, e.idx, e.last, e.due);
                    end
                end
            end
            if (en) m_en++;
        end
    end

    task automatic drive(input logic v, input logic a, input int k);
        @(posedge clk);
        #1;
        in_valid = v;
        exp_acc = a;
        exp_k = k;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, en, in_zero, busy, out_valid, out_last} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b want=100000", {in_ready, en, in_zero, busy, out_valid, out_last});
        end
        n_cmp++;
        if (stage_bf !== '0 || tw_addr !== '0 || out_index !== '0) begin
            n_bad++;
            $display("FAIL reset_data got bf=%b tw=%h idx=%0d want 0", stage_bf, tw_addr, out_index);
        end
    endtask

    task automatic test_single_frame;
        int t = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, i);
            n_cmp++;
            if ({in_ready, en, busy} !== {2'b11, i != 0}) begin
                n_bad++;
                $display("FAIL sf_accept i=%0d got=%b want=%b", i, {in_ready, en, busy}, {2'b11, i != 0});
            end
            n_cmp++;
            if (stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL sf_stage t=%0d got bf=%b tw=%h want bf=%b tw=%h", t, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if ({in_ready, en, busy, in_zero} !== 4'b1010) begin
            n_bad++;
            $display("FAIL sf_boundary got=%b want=1010", {in_ready, en, busy, in_zero});
        end
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 1'b0, 0);
            n_cmp++;
            if ({in_ready, en, in_zero, out_valid, out_last} !== {3'b011, i >= 4, i == 35}) begin
                n_bad++;
                $display("FAIL sf_flush i=%0d got=%b want=%b", i, {in_ready, en, in_zero, out_valid, out_last},
                         {3'b011, i >= 4, i == 35});
            end
            n_cmp++;
            if (stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL sf_flush_stage t=%0d got bf=%b tw=%h want bf=%b tw=%h", t, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            if (t == 37) begin
                n_cmp++;
                if (out_index !== 5'd16) begin
                    n_bad++;
                    $display("FAIL sf_second_bin got=%0d want=16", out_index);
                end
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if ({busy, in_ready, out_valid, en} !== 4'b0100) begin
            n_bad++;
            $display("FAIL sf_idle got=%b want=0100", {busy, in_ready, out_valid, en});
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sf_drain got=%0d pending want=0", sb.size());
        end
    endtask

    task automatic test_continuous;
        int t = 0;
        for (int i = 0; i < 96; i++) begin
            drive(1'b1, 1'b1, i);
            n_cmp++;
            if ({in_ready, en, in_zero} !== 3'b110) begin
                n_bad++;
                $display("FAIL bb_ready i=%0d got=%b want=110", i, {in_ready, en, in_zero});
            end
            n_cmp++;
            if (stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL bb_stage t=%0d got bf=%b tw=%h want bf=%b tw=%h", t, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            if (t == 35) begin
                n_cmp++;
                if (tw_addr[3:0] !== 4'd3) begin
                    n_bad++;
                    $display("FAIL bb_tw0_t35 got=%0d want=3", tw_addr[3:0]);
                end
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 1'b0, 0);
            n_cmp++;
            if ({in_ready, en} !== 2'b01 || stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL bb_flush t=%0d got rdy/en=%b bf=%b tw=%h want 01 bf=%b tw=%h", t,
                         {in_ready, en}, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL bb_end got busy=%b pending=%0d want busy=0 pending=0", busy, sb.size());
        end
    endtask

    task automatic test_stall;
        int t = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, i);
            n_cmp++;
            if (stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL st_stage t=%0d got bf=%b tw=%h want bf=%b tw=%h", t, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            t++;
            if (i == 10)
                for (int j = 0; j < 5; j++) begin
                    drive(1'b0, 1'b0, 0);
                    n_cmp++;
                    if ({en, in_ready, busy, out_valid} !== 4'b0110 || stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                        n_bad++;
                        $display("FAIL st_hold j=%0d got ctl=%b bf=%b tw=%h want 0110 bf=%b tw=%h", j,
                                 {en, in_ready, busy, out_valid}, stage_bf, tw_addr, m_bf(t), m_tw(t));
                    end
                end
        end
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 1'b0, 0);
            n_cmp++;
            if ({in_ready, en, out_last} !== {2'b01, i == 35} || stage_bf !== m_bf(t)) begin
                n_bad++;
                $display("FAIL st_flush i=%0d got ctl=%b bf=%b want %b bf=%b", i, {in_ready, en, out_last},
                         stage_bf, {2'b01, i == 35}, m_bf(t));
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL st_end got busy=%b pending=%0d want busy=0 pending=0", busy, sb.size());
        end
    endtask

    task automatic test_gap;
        int t = 1;
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, i);
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if ({en, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL gap_boundary got=%b want=01", {en, in_ready});
        end
        for (int i = 0; i < 36; i++) begin
            drive(1'b1, 1'b0, 0);
            n_cmp++;
            if ({in_ready, en, in_zero, busy} !== 4'b0111) begin
                n_bad++;
                $display("FAIL gap_flush i=%0d got=%b want=0111", i, {in_ready, en, in_zero, busy});
            end
        end
        drive(1'b1, 1'b1, 0);
        n_cmp++;
        if ({busy, in_ready, en} !== 3'b011 || stage_bf !== '0 || tw_addr !== '0) begin
            n_bad++;
            $display("FAIL gap_restart got ctl=%b bf=%b tw=%h want 011 bf=0 tw=0", {busy, in_ready, en}, stage_bf, tw_addr);
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, i);
            n_cmp++;
            if (stage_bf !== m_bf(t) || tw_addr !== m_tw(t)) begin
                n_bad++;
                $display("FAIL gap_stage t=%0d got bf=%b tw=%h want bf=%b tw=%h", t, stage_bf, tw_addr, m_bf(t), m_tw(t));
            end
            t++;
        end
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 36; i++) drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL gap_end got busy=%b pending=%0d want busy=0 pending=0", busy, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, i);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_acc = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid, en, in_ready} !== 4'b0001 || stage_bf !== '0 || tw_addr !== '0) begin
            n_bad++;
            $display("FAIL rm_idle got ctl=%b bf=%b tw=%h want 0001 bf=0 tw=0", {busy, out_valid, en, in_ready}, stage_bf, tw_addr);
        end
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, i);
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 1'b0, 0);
            n_cmp++;
            if ({in_ready, en, out_valid} !== {2'b01, i >= 4}) begin
                n_bad++;
                $display("FAIL rm_flush i=%0d got=%b want=%b", i, {in_ready, en, out_valid}, {2'b01, i >= 4});
            end
        end
        drive(1'b0, 1'b0, 0);
        n_cmp++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rm_end got busy=%b pending=%0d want busy=0 pending=0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_continuous;
        test_stall;
        test_gap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
